// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle RV32 datapath: sequences fetch/decode/execute/memory/writeback
// and drives ALU-op, datapath selects and write strobes, with a ready handshake on the memory port.
module multicycle_control_fsm #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [6:0]          opcode_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic [1:0]          alu_op_o,
  output logic [1:0]          alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          result_src_o,
  output logic                adr_src_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                reg_write_o,
  output logic                halted_o,
  output logic                retire_o,
  output logic [RETIRE_W-1:0] retire_cnt_o
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_HALT
  } state_t;

  state_t              state_reg, state_next;
  logic [RETIRE_W-1:0] retire_cnt_reg;
  logic                pc_update, branch;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= S_FETCH;
      retire_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire_o) retire_cnt_reg <= retire_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    alu_op_o     = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    result_src_o = 2'b00;
    adr_src_o    = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_update    = 1'b0;
    branch       = 1'b0;
    reg_write_o  = 1'b0;
    halted_o     = 1'b0;
    retire_o     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_update    = mem_ready_i;
        if (mem_ready_i) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (opcode_i)
          OP_R:          state_next = S_EXEC_R;
          OP_I:          state_next = S_EXEC_I;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ:        state_next = S_BRANCH;
          OP_JAL:        state_next = S_JAL;
          default:       state_next = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
        state_next  = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b11;
        state_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_next  = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        retire_o     = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        adr_src_o = 1'b1;
        retire_o  = mem_ready_i;
        if (mem_ready_i) state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        branch      = 1'b1;
        retire_o    = 1'b1;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_update   = 1'b1;
        state_next  = S_ALU_WB;
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: state_next = S_HALT;
    endcase

    pc_write_o = pc_update | (branch & zero_i);

    // Reset overrides every output, so an abandoned request leaves no stray strobe.
    if (rst_i) begin
      alu_op_o     = 2'b00;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      result_src_o = 2'b00;
      adr_src_o    = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      halted_o     = 1'b0;
      retire_o     = 1'b0;
    end
  end

  assign retire_cnt_o = retire_cnt_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: a per-cycle vector table plus hand-written
// sequences for wait states, halt, counter wrap and reset during a pending store.
module tb_multicycle_control_fsm;

  localparam int RW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [6:0]    opcode_i = 7'b0;
  logic          zero_i = 1'b0;
  logic          mem_ready_i = 1'b0;
  logic [1:0]    alu_op_o, alu_src_a_o, alu_src_b_o, result_src_o;
  logic          adr_src_o, mem_req_o, mem_we_o, ir_write_o, pc_write_o;
  logic          reg_write_o, halted_o, retire_o;
  logic [RW-1:0] retire_cnt_o;

  multicycle_control_fsm #(.RETIRE_W(RW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .result_src_o(result_src_o), .adr_src_o(adr_src_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .ir_write_o(ir_write_o),
    .pc_write_o(pc_write_o), .reg_write_o(reg_write_o), .halted_o(halted_o),
    .retire_o(retire_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  typedef enum {T_FETCH, T_DECODE, T_EXEC_R, T_EXEC_I, T_ALU_WB, T_MEM_ADDR,
                T_MEM_READ, T_MEM_WB, T_MEM_WRITE, T_BRANCH, T_JAL, T_HALT} tst_e;

  typedef struct packed {
    logic [1:0] alu_op, src_a, src_b, result_src;
    logic adr_src, mem_req, mem_we, ir_write, pc_write, reg_write, halted, retire;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       ready;
    tst_e       st;
  } vec_t;

  vec_t    vecs[$];
  outs_t   exp_q[$];
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  int      ir_pulses = 0;
  logic [RW-1:0] cnt_model = '0;
  bit      cnt_valid = 0;

  // Expected outputs for the state the DUT should be in, straight from the control table.
  function automatic outs_t exp_out(tst_e st, logic rst, logic z, logic r);
    outs_t o = '0;
    if (rst) return o;
    case (st)
      T_FETCH:     begin o.mem_req = 1; o.src_b = 2'b10; o.result_src = 2'b10;
                         o.ir_write = r; o.pc_write = r; end
      T_DECODE:    begin o.src_a = 2'b01; o.src_b = 2'b01; end
      T_EXEC_R:    begin o.src_a = 2'b10; o.alu_op = 2'b10; end
      T_EXEC_I:    begin o.src_a = 2'b10; o.src_b = 2'b01; o.alu_op = 2'b11; end
      T_ALU_WB:    begin o.reg_write = 1; o.retire = 1; end
      T_MEM_ADDR:  begin o.src_a = 2'b10; o.src_b = 2'b01; end
      T_MEM_READ:  begin o.mem_req = 1; o.adr_src = 1; end
      T_MEM_WB:    begin o.result_src = 2'b01; o.reg_write = 1; o.retire = 1; end
      T_MEM_WRITE: begin o.mem_req = 1; o.mem_we = 1; o.adr_src = 1; o.retire = r; end
      T_BRANCH:    begin o.src_a = 2'b10; o.alu_op = 2'b01; o.pc_write = z; o.retire = 1; end
      T_JAL:       begin o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1; end
      T_HALT:      o.halted = 1;
      default:     o = '0;
    endcase
    return o;
  endfunction

  function automatic void add(logic rst, logic [6:0] op, logic z, logic r, tst_e st);
    vec_t v;
    v.rst = rst; v.op = op; v.zero = z; v.ready = r; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic [6:0] op, input logic z,
                      input logic r, input tst_e st);
    outs_t e, a;
    @(posedge clk_i); #1;
    rst_i = rst; opcode_i = op; zero_i = z; mem_ready_i = r;
    exp_q.push_back(exp_out(st, rst, z, r));
    @(negedge clk_i);
    e = exp_q.pop_front();
    a = {alu_op_o, alu_src_a_o, alu_src_b_o, result_src_o, adr_src_o, mem_req_o,
         mem_we_o, ir_write_o, pc_write_o, reg_write_o, halted_o, retire_o};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL outs cyc=%0d st=%s got=%b required=%b", cyc, st.name(), a, e);
    end
    if (cnt_valid) begin
      checks++;
      if (retire_cnt_o !== cnt_model) begin
        failures++;
        $display("FAIL retire_cnt cyc=%0d got=%0d required=%0d", cyc, retire_cnt_o, cnt_model);
      end
    end
    if (ir_write_o === 1'b1) ir_pulses++;
    if (rst) begin
      cnt_model = '0;
      cnt_valid = 1;
    end else if (e.retire) begin
      cnt_model = cnt_model + 1'b1;
    end
    $display("cyc=%0d rst=%b op=%b rdy=%b z=%b st=%s outs=%b cnt=%0d",
             cyc, rst, op, r, z, st.name(), a, retire_cnt_o);
    cyc++;
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  initial begin
    // Reset, R-type, both BEQ outcomes, I-ALU, JAL, zero-wait SW.
    for (int i = 0; i < 3; i++) add(1, 7'b0, 0, 1, T_FETCH);
    add(0, OP_R, 0, 1, T_FETCH); add(0, OP_R, 0, 1, T_DECODE);
    add(0, OP_R, 0, 1, T_EXEC_R); add(0, OP_R, 0, 1, T_ALU_WB);
    add(0, OP_BEQ, 1, 1, T_FETCH); add(0, OP_BEQ, 1, 1, T_DECODE);
    add(0, OP_BEQ, 1, 1, T_BRANCH);
    add(0, OP_BEQ, 0, 1, T_FETCH); add(0, OP_BEQ, 0, 1, T_DECODE);
    add(0, OP_BEQ, 0, 1, T_BRANCH);
    add(0, OP_I, 1, 1, T_FETCH); add(0, OP_I, 1, 0, T_DECODE);
    add(0, OP_I, 1, 1, T_EXEC_I); add(0, OP_I, 0, 1, T_ALU_WB);
    add(0, OP_JAL, 0, 1, T_FETCH); add(0, OP_JAL, 0, 1, T_DECODE);
    add(0, OP_JAL, 0, 1, T_JAL); add(0, OP_JAL, 0, 1, T_ALU_WB);
    add(0, OP_SW, 0, 1, T_FETCH); add(0, OP_SW, 0, 1, T_DECODE);
    add(0, OP_SW, 0, 1, T_MEM_ADDR); add(0, OP_SW, 0, 1, T_MEM_WRITE);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].ready, vecs[i].st);
    check_val("cnt_after_table", int'(retire_cnt_o), 5);

    // LW: 2 wait cycles in FETCH, 3 in MEM_READ -> 10 cycles, one IR load.
    ir_pulses = 0;
    step(0, OP_LW, 0, 0, T_FETCH); step(0, OP_LW, 0, 0, T_FETCH);
    step(0, OP_LW, 0, 1, T_FETCH); step(0, OP_LW, 0, 1, T_DECODE);
    step(0, OP_LW, 0, 1, T_MEM_ADDR);
    for (int i = 0; i < 3; i++) step(0, OP_LW, 1, 0, T_MEM_READ);
    step(0, OP_LW, 0, 1, T_MEM_READ); step(0, OP_LW, 0, 1, T_MEM_WB);
    check_val("lw_ir_pulses", ir_pulses, 1);

    // Illegal opcode halts; ready/zero activity must not leak through.
    step(0, OP_BAD, 0, 1, T_FETCH); step(0, OP_BAD, 0, 1, T_DECODE);
    for (int i = 0; i < 20; i++)
      step(0, OP_BAD, 1'($urandom_range(1)), 1'($urandom_range(1)), T_HALT);
    step(1, OP_BAD, 0, 1, T_HALT);
    step(0, OP_SW, 0, 0, T_FETCH);
    check_val("cnt_after_halt_reset", int'(retire_cnt_o), 0);

    // 17 back-to-back stores wrap the 4-bit counter to 1.
    step(0, OP_SW, 0, 1, T_FETCH);
    for (int n = 0; n < 17; n++) begin
      if (n != 0) step(0, OP_SW, 0, 1, T_FETCH);
      step(0, OP_SW, 0, 1, T_DECODE);
      step(0, OP_SW, 0, 1, T_MEM_ADDR);
      step(0, OP_SW, 0, 1, T_MEM_WRITE);
    end
    step(0, OP_SW, 0, 0, T_FETCH);
    check_val("cnt_wrap", int'(retire_cnt_o), 1);

    // Reset while a store waits: no strobes even with ready high, back to FETCH, count cleared.
    step(0, OP_SW, 0, 1, T_FETCH); step(0, OP_SW, 0, 1, T_DECODE);
    step(0, OP_SW, 0, 1, T_MEM_ADDR);
    step(0, OP_SW, 0, 0, T_MEM_WRITE); step(0, OP_SW, 0, 0, T_MEM_WRITE);
    step(1, OP_SW, 0, 1, T_MEM_WRITE);
    step(0, OP_R, 0, 0, T_FETCH);
    check_val("cnt_after_mid_reset", int'(retire_cnt_o), 0);
    step(0, OP_R, 0, 1, T_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
